pal_cfg_loader: RTL and testbench

Configuration sequencer for the PAL fabric. Accepts a configuration bitstream as bytes over a valid/ready handshake and serializes it LSB-first onto the PAL's one-bit config chain (CFG_BIT qualified by CFG_SHIFT). It verifies a trailing XOR checksum, then raises CFG_EN to make the loaded configuration live. It sits between the byte source (host interface or bitstream ROM) and the PAL's CFG/EN inputs, on the same clock as the PAL.

---
 rtl/pal_cfg_loader.sv | 150 +++++++++++++++
 tb/tb_pal_cfg_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pal_cfg_loader.sv
// ---------------------------------------------------------------------------
// pal_cfg_loader
//
// Configuration sequencer for the PAL fabric. Takes the bitstream as bytes
// over a valid/ready handshake, shifts each byte LSB-first onto the PAL's
// one-bit config chain, checks a trailing XOR checksum byte and, when the
// checksum matches, raises cfg_en to make the loaded configuration live.
//
// Parameters
//   CHAIN_LEN  total config-chain bits (payload bytes = ceil(CHAIN_LEN/8))
//
// Ports
//   clk        in   rising-edge clock, shared with the PAL
//   res_n      in   asynchronous active-low reset
//   start      in   begin a load (honoured only in IDLE, DONE or ERROR)
//   abort      in   abandon any load, highest priority
//   din        in   payload or checksum byte
//   din_valid  in   din is valid
//   din_ready  out  loader accepts din this cycle
//   cfg_bit    out  serial config bit to the PAL CFG input
//   cfg_shift  out  cfg_bit is valid; the PAL shifts its chain this cycle
//   cfg_en     out  configuration live (PAL EN input)
//   busy       out  load in progress (LOAD, SHIFT or CHECK)
//   done       out  last load completed with a good checksum
//   err        out  last load failed its checksum
// ---------------------------------------------------------------------------
module pal_cfg_loader #(
    parameter int CHAIN_LEN = 280
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       cfg_bit,
    output logic       cfg_shift,
    output logic       cfg_en,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int NBYTES = (CHAIN_LEN + 7) / 8;
    // Bits of the final payload byte that actually enter the chain (1..8).
    localparam int TAIL   = CHAIN_LEN - 8 * (NBYTES - 1);
    localparam int BCW    = $clog2(NBYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [BCW-1:0] byte_cnt;
    logic [3:0]     bit_cnt;
    logic [7:0]     csum;
    logic [7:0]     sreg;

    logic hs;
    logic last_byte;
    logic last_bit;

    // Every output is a decode of registered state, so nothing on the din
    // side can ripple combinationally into din_ready.
    assign din_ready = (state == S_LOAD) || (state == S_CHECK);
    assign cfg_shift = (state == S_SHIFT);
    assign cfg_bit   = (state == S_SHIFT) & sreg[0];
    assign cfg_en    = (state == S_DONE);
    assign done      = (state == S_DONE);
    assign err       = (state == S_ERROR);
    assign busy      = (state == S_LOAD) || (state == S_SHIFT) || (state == S_CHECK);

    assign hs        = din_valid & din_ready;
    // byte_cnt still holds the index of the byte being shifted.
    assign last_byte = (byte_cnt == BCW'(NBYTES - 1));
    assign last_bit  = (bit_cnt == 4'd1);

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = S_LOAD;
                S_LOAD:                  if (hs) state_nxt = S_SHIFT;
                S_SHIFT:                 if (last_bit) state_nxt = last_byte ? S_CHECK : S_LOAD;
                S_CHECK:                 if (hs) state_nxt = (din == csum) ? S_DONE : S_ERROR;
                default:                 state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            // NOTE: non-blocking assignments so all registers update together at the edge.
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            byte_cnt <= '0;
            bit_cnt  <= '0;
            csum     <= '0;
            sreg     <= '0;
        end else if (abort) begin
            // A partially shifted byte is dropped along with all progress.
            byte_cnt <= '0;
            bit_cnt  <= '0;
            csum     <= '0;
            sreg     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        byte_cnt <= '0;
                        bit_cnt  <= '0;
                        csum     <= '0;
                        sreg     <= '0;
                    end
                end
                S_LOAD: begin
                    if (hs) begin
                        sreg <= din;
                        // Unshifted high bits of the final byte still count here.
                        csum    <= csum ^ din;
                        bit_cnt <= last_byte ? 4'(TAIL) : 4'd8;
                    end
                end
                S_SHIFT: begin
                    sreg    <= {1'b0, sreg[7:1]};
                    bit_cnt <= bit_cnt - 4'd1;
                    if (last_bit) byte_cnt <= byte_cnt + BCW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_pal_cfg_loader
//
// Scoreboard bench for pal_cfg_loader. Two instances: a 280-bit chain and a
// 283-bit chain (short final byte). The stimulus pushes the expected serial
// bits into a queue per instance as each byte is offered; a monitor pops
// and compares on every cfg_shift cycle. Flag/handshake expectations are
// hand-written constants checked at the falling edge.
//
// Payload 0x00..0x22: the XOR of 0x00..0x22 is 0x23 (good checksum); 0x22
// is therefore a bad checksum. With a final byte 0xFF appended the good
// checksum is 0x23 ^ 0xFF = 0xDC.
// ---------------------------------------------------------------------------
module tb_pal_cfg_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       res_n;
    logic       start_a, abort_a, valid_a;
    logic [7:0] din_a;
    logic       ready_a, bit_a, shift_a, en_a, busy_a, done_a, err_a;
    logic       start_b, abort_b, valid_b;
    logic [7:0] din_b;
    logic       ready_b, bit_b, shift_b, en_b, busy_b, done_b, err_b;

    pal_cfg_loader #(.CHAIN_LEN(280)) dut_a (
        .clk(clk), .res_n(res_n), .start(start_a), .abort(abort_a),
        .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
        .cfg_bit(bit_a), .cfg_shift(shift_a), .cfg_en(en_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    pal_cfg_loader #(.CHAIN_LEN(283)) dut_b (
        .clk(clk), .res_n(res_n), .start(start_b), .abort(abort_b),
        .din(din_b), .din_valid(valid_b), .din_ready(ready_b),
        .cfg_bit(bit_b), .cfg_shift(shift_b), .cfg_en(en_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    int checks   = 0;
    int failures = 0;
    bit exp_a[$];
    bit exp_b[$];
    int shifts_a = 0;
    int shifts_b = 0;
    bit cont_mode = 1'b0;
    int cyc = 0;
    int last_rdy_cyc = -1;

    // Output vector order: {din_ready, cfg_shift, cfg_bit, cfg_en, busy, done, err}
    localparam logic [6:0] O_IDLE  = 7'b000_0000;
    localparam logic [6:0] O_LOAD  = 7'b100_0100;
    localparam logic [6:0] O_DONE  = 7'b000_1010;
    localparam logic [6:0] O_ERROR = 7'b000_0001;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] outs(input int d);
        if (d == 0) return {ready_a, shift_a, bit_a, en_a, busy_a, done_a, err_a};
        return {ready_b, shift_b, bit_b, en_b, busy_b, done_b, err_b};
    endfunction

    function automatic logic rdy(input int d);
        return (d == 0) ? ready_a : ready_b;
    endfunction

    // Monitor: pops the scoreboard on every shift cycle.
    always @(negedge clk) begin
        cyc++;
        if (res_n) begin
            if (shift_a) begin
                shifts_a++;
                if (exp_a.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL a_extra_shift: got cfg_shift=1 expected no shift (queue empty)");
                end else check("a_cfg_bit", 32'(bit_a), 32'(exp_a.pop_front()));
            end else if (bit_a) check("a_cfg_bit_idle", 32'(bit_a), 0);
            if (shift_b) begin
                shifts_b++;
                if (exp_b.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b_extra_shift: got cfg_shift=1 expected no shift (queue empty)");
                end else check("b_cfg_bit", 32'(bit_b), 32'(exp_b.pop_front()));
            end else if (bit_b) check("b_cfg_bit_idle", 32'(bit_b), 0);
            if (cont_mode && ready_a) begin
                if (last_rdy_cyc >= 0) check("a_ready_spacing_ge9", 32'(cyc - last_rdy_cyc >= 9), 1);
                last_rdy_cyc = cyc;
            end
        end
    end

    task automatic set_start(input int d, input logic v);
        if (d == 0) start_a = v; else start_b = v;
    endtask

    task automatic set_abort(input int d, input logic v);
        if (d == 0) abort_a = v; else abort_b = v;
    endtask

    task automatic set_din(input int d, input logic v, input logic [7:0] x);
        if (d == 0) begin valid_a = v; din_a = x; end
        else begin valid_b = v; din_b = x; end
    endtask

    // Called and returns at 1 ns after a rising edge.
    task automatic pulse_start(input int d);
        set_start(d, 1'b1);
        @(posedge clk); #1;
        set_start(d, 1'b0);
    endtask

    // Offers one byte; returns 1 ns after the handshake edge (first shift cycle).
    task automatic send_byte(input int d, input logic [7:0] x, input int nbits, input bit keep);
        int n = 0;
        set_din(d, 1'b1, x);
        @(negedge clk);
        while (!rdy(d) && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (!rdy(d)) begin
            checks++; failures++;
            $display("FAIL din_ready_timeout: got din_ready=0 for 40 cycles expected 1 (dut %0d)", d);
        end
        for (int i = 0; i < nbits; i++) begin
            if (d == 0) exp_a.push_back(x[i]); else exp_b.push_back(x[i]);
        end
        @(posedge clk); #1;
        if (!keep) set_din(d, 1'b0, x);
    endtask

    task automatic full_load(input int d, input logic [7:0] ck, input bit keep);
        int nb = (d == 0) ? 35 : 36;
        for (int i = 0; i < nb; i++) begin
            if (d == 1 && i == 35) send_byte(d, 8'hFF, 3, keep);
            else send_byte(d, 8'(i), 8, keep);
        end
        send_byte(d, ck, 0, 1'b0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish expected finish within 3 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        res_n = 1'b0;
        start_a = 0; abort_a = 0; valid_a = 0; din_a = '0;
        start_b = 0; abort_b = 0; valid_b = 0; din_b = '0;
        #3;
        check("reset_outs_a", 32'(outs(0)), 32'(O_IDLE));
        check("reset_outs_b", 32'(outs(1)), 32'(O_IDLE));
        @(posedge clk); #1 res_n = 1'b1;
        @(negedge clk);
        check("post_reset_outs_a", 32'(outs(0)), 32'(O_IDLE));
        @(posedge clk); #1;

        // Good load on the 280-bit chain.
        pulse_start(0);
        @(negedge clk);
        check("start_outs", 32'(outs(0)), 32'(O_LOAD));
        @(posedge clk); #1;
        shifts_a = 0;
        full_load(0, 8'h23, 0);
        @(negedge clk);
        check("good_done_outs", 32'(outs(0)), 32'(O_DONE));
        check("good_shift_count", 32'(shifts_a), 280);
        check("good_queue_drained", 32'(exp_a.size()), 0);
        @(posedge clk); #1;

        // Bad checksum, then restart out of ERROR.
        pulse_start(0);
        full_load(0, 8'h22, 0);
        @(negedge clk);
        check("bad_err_outs", 32'(outs(0)), 32'(O_ERROR));
        @(posedge clk); #1;
        pulse_start(0);
        @(negedge clk);
        check("restart_from_err", 32'(outs(0)), 32'(O_LOAD));
        @(posedge clk); #1;
        full_load(0, 8'h23, 0);
        @(negedge clk);
        check("reload_done_outs", 32'(outs(0)), 32'(O_DONE));
        @(posedge clk); #1;

        // 283-bit chain: final byte 0xFF shifts 3 bits, checksum uses all 8.
        pulse_start(1);
        shifts_b = 0;
        full_load(1, 8'hDC, 0);
        @(negedge clk);
        check("tail_done_outs", 32'(outs(1)), 32'(O_DONE));
        check("tail_shift_count", 32'(shifts_b), 283);
        check("tail_queue_drained", 32'(exp_b.size()), 0);
        @(posedge clk); #1;

        // Abort during the 4th shift cycle of byte 10.
        pulse_start(0);
        for (int i = 0; i <= 10; i++) send_byte(0, 8'(i), 8, 0);
        repeat (3) @(posedge clk);
        #1 set_abort(0, 1'b1);
        @(posedge clk); #1 set_abort(0, 1'b0);
        @(negedge clk);
        check("abort_outs", 32'(outs(0)), 32'(O_IDLE));
        check("abort_bits_left", 32'(exp_a.size()), 4);
        exp_a.delete();
        @(posedge clk); #1;
        pulse_start(0);
        full_load(0, 8'h23, 0);
        @(negedge clk);
        check("after_abort_done", 32'(outs(0)), 32'(O_DONE));
        @(posedge clk); #1;

        // din_valid held high, mid-load START ignored.
        pulse_start(0);
        last_rdy_cyc = -1;
        cont_mode = 1'b1;
        shifts_a = 0;
        for (int i = 0; i < 35; i++) begin
            send_byte(0, 8'(i), 8, 1);
            if (i == 5) begin
                set_start(0, 1'b1);
                @(posedge clk); #1 set_start(0, 1'b0);
                @(negedge clk);
                check("midload_start_busy", 32'(busy_a), 1);
                check("midload_start_shifting", 32'(shift_a), 1);
                @(posedge clk); #1;
            end
        end
        send_byte(0, 8'h23, 0, 0);
        cont_mode = 1'b0;
        @(negedge clk);
        check("cont_done_outs", 32'(outs(0)), 32'(O_DONE));
        check("cont_shift_count", 32'(shifts_a), 280);
        @(posedge clk); #1;

        // START and ABORT together in DONE.
        set_start(0, 1'b1); set_abort(0, 1'b1);
        @(posedge clk); #1;
        set_start(0, 1'b0); set_abort(0, 1'b0);
        @(negedge clk);
        check("start_abort_outs", 32'(outs(0)), 32'(O_IDLE));
        @(negedge clk);
        check("start_abort_stays_idle", 32'(outs(0)), 32'(O_IDLE));
        @(posedge clk); #1;

        // Asynchronous reset mid-shift.
        pulse_start(0);
        for (int i = 0; i < 3; i++) send_byte(0, 8'(i), 8, 0);
        #2 res_n = 1'b0;
        #1;
        check("async_reset_outs", 32'(outs(0)), 32'(O_IDLE));
        exp_a.delete();
        repeat (3) @(posedge clk);
        #1 res_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_async_reset_idle", 32'(outs(0)), 32'(O_IDLE));
        end
        @(posedge clk); #1;
        pulse_start(0);
        full_load(0, 8'h23, 0);
        @(negedge clk);
        check("after_reset_done", 32'(outs(0)), 32'(O_DONE));

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
